// File: rtl/mem_io_responder.sv
// Byte-wide memory/IO responder for the core: on-chip RAM below the IO window,
// plus a UART TX FIFO, an RX byte port and a sticky halt register inside it.
module mem_io_responder #(
    parameter int RAM_AW      = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ack,
    output logic        halt,
    output logic        tx_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C       = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL_THRESH_C = CW'(FIFO_DEPTH - FULL_MARGIN);
    localparam logic [17:0]   ADDR_UART     = 18'h30000;
    localparam logic [17:0]   ADDR_HALT     = 18'h30004;

    // Address decode; bits above 17 alias by design.
    logic [17:0]       addr;
    logic              is_io;
    logic [RAM_AW-1:0] ram_idx;
    logic              unused_addr_bits;

    assign addr             = mem_a[17:0];
    assign is_io            = (addr[17:16] == 2'b11);
    assign ram_idx          = mem_a[RAM_AW-1:0];
    assign unused_addr_bits = ^mem_a[31:18];

    logic bus_wr;
    logic bus_rd;
    logic ram_we;
    logic push_req;
    logic halt_set;
    logic rx_rd;

    assign bus_wr   = rdy_in && mem_wr;
    assign bus_rd   = rdy_in && !mem_wr;
    assign ram_we   = bus_wr && !is_io;
    assign push_req = bus_wr && (addr == ADDR_UART);
    assign halt_set = bus_wr && (addr == ADDR_HALT);
    assign rx_rd    = bus_rd && (addr == ADDR_UART);

    // ---------------------------------------------------------------------
    // Byte RAM with registered, write-first read port; never reset so its
    // contents survive a reset and it maps onto block RAM.
    // ---------------------------------------------------------------------
    logic [7:0] ram_mem [0:(2**RAM_AW)-1];
    logic [7:0] ram_rd_reg;

    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram_mem[ram_idx] <= mem_dout;
        end
        if (rdy_in && !is_io) begin
            ram_rd_reg <= mem_wr ? mem_dout : ram_mem[ram_idx];
        end
    end

    // ---------------------------------------------------------------------
    // TX FIFO
    // ---------------------------------------------------------------------
    logic [7:0]    fifo_mem [0:FIFO_DEPTH-1];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          fifo_empty;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          overflow_set;

    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = (count_reg == DEPTH_C);
    assign pop        = !fifo_empty && tx_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // still lands when the UART is draining.
    assign push         = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= mem_dout;
        end
    end

    assign tx_valid       = !fifo_empty;
    assign tx_data        = fifo_mem[rd_ptr_reg];
    assign io_buffer_full = (count_reg >= FULL_THRESH_C);

    // ---------------------------------------------------------------------
    // IO read data and control registers
    // ---------------------------------------------------------------------
    logic [7:0] io_rd_next;
    logic [7:0] io_rd_reg;
    logic       sel_ram_reg;
    logic       rx_ack_reg;
    logic       halt_reg;
    logic       tx_overflow_reg;

    always_comb begin
        io_rd_next = 8'h00;
        if (addr == ADDR_UART) begin
            io_rd_next = rx_valid ? rx_data : 8'h00;
        end else if (addr == ADDR_HALT) begin
            io_rd_next = {7'b0, fifo_empty};
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            sel_ram_reg     <= 1'b0;
            io_rd_reg       <= 8'h00;
            rx_ack_reg      <= 1'b0;
            halt_reg        <= 1'b0;
            tx_overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            rx_ack_reg <= rx_rd && rx_valid;
            if (halt_set) begin
                halt_reg <= 1'b1;
            end
            if (overflow_set) begin
                tx_overflow_reg <= 1'b1;
            end
            // mem_din source tracks the last accepted access; IO writes leave it alone.
            if (rdy_in && !is_io) begin
                sel_ram_reg <= 1'b1;
            end else if (bus_rd) begin
                sel_ram_reg <= 1'b0;
                io_rd_reg   <= io_rd_next;
            end
        end
    end

    assign mem_din     = sel_ram_reg ? ram_rd_reg : io_rd_reg;
    assign rx_ack      = rx_ack_reg;
    assign halt        = halt_reg;
    assign tx_overflow = tx_overflow_reg;

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus randomized
// traffic, compared against a queue/array reference model of the bus rules.
module tb_mem_io_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;
    localparam int AW     = 17;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ack;
    logic        halt;
    logic        tx_overflow;

    always #5 clk_in = ~clk_in;

    mem_io_responder #(.RAM_AW(AW), .FIFO_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .mem_a(mem_a),
        .mem_wr(mem_wr), .mem_dout(mem_dout), .mem_din(mem_din),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .halt(halt), .tx_overflow(tx_overflow)
    );

    // Reference model state
    logic [7:0] ram_m [0:(1<<AW)-1];
    bit         ram_v [0:(1<<AW)-1];
    logic [7:0] q[$];
    logic [7:0] exp_din;
    bit         din_known;
    bit         exp_ack, exp_halt, exp_ovf;
    int         checks = 0;
    int         errors = 0;
    logic [16:0] pool [16];

    task automatic model_reset();
        q.delete();
        exp_din = 8'h00; din_known = 1; exp_ack = 0; exp_halt = 0; exp_ovf = 0;
    endtask

    task automatic drive(input logic r, input logic wr, input logic [31:0] a, input logic [7:0] d);
        rdy_in = r; mem_wr = wr; mem_a = a; mem_dout = d;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 32'h0003_0008, 8'h00);
    endtask

    // Advance one clock; the model applies the bus rules to the inputs seen at the edge.
    task automatic step();
        logic [17:0] a;
        bit io, pop, full_before, push_req;
        int idx;
        a = mem_a[17:0];
        io = (a[17:16] == 2'b11);
        idx = int'(mem_a[AW-1:0]);
        full_before = (q.size() == DEPTH);
        pop = (q.size() != 0) && tx_ready;
        push_req = 0;
        exp_ack = 0;
        if (rdy_in) begin
            if (!io) begin
                if (mem_wr) begin
                    ram_m[idx] = mem_dout; ram_v[idx] = 1; exp_din = mem_dout; din_known = 1;
                end else begin
                    exp_din = ram_m[idx]; din_known = ram_v[idx];
                end
            end else if (mem_wr) begin
                din_known = 0;
                if (a == 18'h30004) exp_halt = 1;
                if (a == 18'h30000) push_req = 1;
            end else begin
                din_known = 1;
                if (a == 18'h30000) begin
                    exp_din = rx_valid ? rx_data : 8'h00;
                    exp_ack = rx_valid;
                end else if (a == 18'h30004) begin
                    exp_din = {7'b0, q.size() == 0};
                end else begin
                    exp_din = 8'h00;
                end
            end
        end
        if (pop) void'(q.pop_front());
        if (push_req) begin
            if (full_before && !pop) exp_ovf = 1;
            else q.push_back(mem_dout);
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        model_reset();
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    function automatic logic [31:0] ram_addr(input logic [16:0] idx);
        logic [31:0] r;
        r = $urandom;
        r[16:0] = idx;
        if (idx[16]) r[17] = 1'b0;
        return r;
    endfunction

    task automatic test_reset();
        rst_n_in = 1'b0; tx_ready = 0; rx_valid = 0; rx_data = 0;
        idle();
        model_reset();
        repeat (2) @(posedge clk_in);
        #1;
        checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got %h exp 00", mem_din); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
        checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", io_buffer_full); end
        checks++; if ({rx_ack, halt, tx_overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {rx_ack, halt, tx_overflow}); end
        rst_n_in = 1'b1;
    endtask

    task automatic test_ram_round_trip();
        drive(1, 1, 32'h0000_0010, 8'hA5); step();
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_write_first got %h exp a5", mem_din); end
        drive(1, 1, 32'h0001_FFFF, 8'h3C); step();
        drive(1, 0, 32'h0000_0010, 8'h00); step();
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_rd_10 got %h exp a5", mem_din); end
        drive(1, 0, 32'h0001_FFFF, 8'h00); step();
        checks++; if (mem_din !== 8'h3C) begin errors++; $display("FAIL ram_rd_1ffff got %h exp 3c", mem_din); end
        drive(1, 0, 32'hFFFE_0010, 8'h00); step();
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_alias got %h exp a5", mem_din); end
        for (int i = 0; i < 80; i++) begin
            drive(1, 1'($urandom_range(0, 1)), ram_addr(pool[$urandom_range(0, 15)]), 8'($urandom));
            step();
            if (din_known) begin
                checks++;
                if (mem_din !== exp_din) begin errors++; $display("FAIL ram_rand[%0d] got %h exp %h", i, mem_din, exp_din); end
            end
        end
    endtask

    task automatic test_fifo_fill_drain();
        do_reset();
        tx_ready = 0;
        for (int i = 1; i <= 8; i++) begin
            drive(1, 1, 32'h0003_0000, 8'(i)); step();
            checks++; if (io_buffer_full !== (i >= DEPTH - MARGIN)) begin errors++; $display("FAIL fill_full[%0d] got %b exp %b", i, io_buffer_full, i >= DEPTH - MARGIN); end
            checks++; if (tx_overflow !== 1'b0 || tx_valid !== 1'b1) begin errors++; $display("FAIL fill_ovf_valid[%0d] got %b%b exp 01", i, tx_overflow, tx_valid); end
        end
        drive(1, 1, 32'h0003_0000, 8'h09); step();
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL ninth_overflow got %b exp 1", tx_overflow); end
        idle(); tx_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin errors++; $display("FAIL drain[%0d] got %b/%h exp 1/%h", i, tx_valid, tx_data, 8'(i)); end
            step();
        end
        checks++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin errors++; $display("FAIL drained got %b%b exp 00", tx_valid, io_buffer_full); end
        // Random interleave exercises pointer wrap.
        for (int i = 0; i < 120; i++) begin
            tx_ready = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) drive(1, 1, 32'h0003_0000, 8'($urandom));
            else idle();
            step();
            checks++;
            if (tx_valid !== (q.size() != 0) || io_buffer_full !== (q.size() >= DEPTH - MARGIN) ||
                (q.size() != 0 && tx_data !== q[0])) begin
                errors++;
                $display("FAIL wrap[%0d] got v=%b f=%b d=%h exp v=%b f=%b d=%h", i, tx_valid, io_buffer_full,
                         tx_data, q.size() != 0, q.size() >= DEPTH - MARGIN, (q.size() != 0) ? q[0] : 8'h00);
            end
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] got [8];
        do_reset();
        tx_ready = 0;
        for (int i = 1; i <= 8; i++) begin drive(1, 1, 32'h0003_0000, 8'(i)); step(); end
        tx_ready = 1;
        drive(1, 1, 32'h0003_0000, 8'h77); step();
        checks++; if (tx_overflow !== 1'b0 || io_buffer_full !== 1'b1) begin errors++; $display("FAIL pp_full got ovf=%b full=%b exp 0/1", tx_overflow, io_buffer_full); end
        idle();
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL pp_valid[%0d] got %b exp 1", i, tx_valid); end
            got[i] = tx_data;
            step();
        end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %b exp 0", tx_valid); end
        checks++; if (got[0] !== 8'h02 || got[7] !== 8'h77) begin errors++; $display("FAIL pp_order got %h..%h exp 02..77", got[0], got[7]); end
    endtask

    task automatic test_rx_port();
        tx_ready = 0;
        rx_valid = 1; rx_data = 8'h42;
        drive(1, 0, 32'h0003_0000, 8'h00); step();
        checks++; if (mem_din !== 8'h42 || rx_ack !== 1'b1) begin errors++; $display("FAIL rx_read got %h/%b exp 42/1", mem_din, rx_ack); end
        rx_valid = 0; idle(); step();
        checks++; if (rx_ack !== 1'b0) begin errors++; $display("FAIL rx_ack_pulse got %b exp 0", rx_ack); end
        drive(1, 0, 32'h0003_0000, 8'h00); step();
        checks++; if (mem_din !== 8'h00 || rx_ack !== 1'b0) begin errors++; $display("FAIL rx_empty got %h/%b exp 00/0", mem_din, rx_ack); end
        drive(1, 0, 32'h0003_0004, 8'h00); step();
        checks++; if (mem_din !== {7'b0, q.size() == 0}) begin errors++; $display("FAIL status_rd got %h exp %h", mem_din, {7'b0, q.size() == 0}); end
        for (int i = 0; i < 20; i++) begin
            rx_valid = 1'($urandom_range(0, 1)); rx_data = 8'($urandom);
            drive(1, 0, 32'h0003_0000, 8'h00); step();
            checks++;
            if (mem_din !== exp_din || rx_ack !== exp_ack) begin errors++; $display("FAIL rx_rand[%0d] got %h/%b exp %h/%b", i, mem_din, rx_ack, exp_din, exp_ack); end
            rx_valid = 0; idle(); step();
        end
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        tx_ready = 0; rx_valid = 0;
        drive(1, 1, 32'h0003_0000, 8'h5A); step();
        drive(1, 0, 32'h0000_0010, 8'h00); step();
        checks++; if (mem_din !== 8'hA5 || tx_data !== 8'h5A) begin errors++; $display("FAIL frz_pre got %h/%h exp a5/5a", mem_din, tx_data); end
        tx_ready = 1;
        drive(0, 1, 32'h0000_0010, 8'h11); step();
        checks++; if (mem_din !== 8'hA5 || tx_valid !== 1'b0) begin errors++; $display("FAIL frz_hold_pop got %h/%b exp a5/0", mem_din, tx_valid); end
        tx_ready = 0;
        drive(0, 1, 32'h0003_0000, 8'h99); step();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL frz_push got %b exp 0", tx_valid); end
        drive(0, 1, 32'h0003_0004, 8'h01); step();
        rx_valid = 1; rx_data = 8'h33;
        drive(0, 0, 32'h0003_0000, 8'h00); step();
        checks++; if (halt !== 1'b0 || rx_ack !== 1'b0 || mem_din !== 8'hA5) begin errors++; $display("FAIL frz_ctrl got h=%b a=%b d=%h exp 0/0/a5", halt, rx_ack, mem_din); end
        rx_valid = 0;
        drive(1, 0, 32'h0000_0010, 8'h00); step();
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL frz_ram got %h exp a5", mem_din); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_ready = 0; rx_valid = 0;
        for (int i = 0; i < 3; i++) begin drive(1, 1, 32'h0003_0000, 8'($urandom)); step(); end
        drive(1, 1, 32'h0003_0004, 8'h00); step();
        drive(1, 0, 32'h0000_0010, 8'h00); step();
        checks++; if (halt !== 1'b1 || tx_valid !== 1'b1 || mem_din !== 8'hA5) begin errors++; $display("FAIL mid_pre got h=%b v=%b d=%h exp 1/1/a5", halt, tx_valid, mem_din); end
        #2;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({mem_din, tx_valid, io_buffer_full, rx_ack, halt, tx_overflow} !== 13'h0) begin
            errors++;
            $display("FAIL mid_async got d=%h v=%b f=%b a=%b h=%b o=%b exp all 0", mem_din, tx_valid, io_buffer_full, rx_ack, halt, tx_overflow);
        end
        @(posedge clk_in); #1;
        rst_n_in = 1'b1;
        drive(1, 0, 32'h0000_0010, 8'h00); step();
        checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL mid_ram_kept got %h exp a5", mem_din); end
    endtask

    task automatic test_random();
        int op;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            rx_valid = 1'($urandom_range(0, 1));
            rx_data  = 8'($urandom);
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ram_addr(pool[$urandom_range(0, 15)]), 8'($urandom));
                3, 4, 5: drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), {$urandom_range(0, 255), 24'h03_0000}, 8'($urandom));
                6:       drive(1, 0, 32'h0003_0004, 8'h00);
                7:       drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h0003_0000 | 32'($urandom_range(1, 255)), 8'($urandom));
                8:       drive(1, 1'($urandom_range(0, 15) == 0), 32'h0003_0004, 8'($urandom));
                default: idle();
            endcase
            step();
            checks++;
            if ((din_known && mem_din !== exp_din) || tx_valid !== (q.size() != 0) ||
                (q.size() != 0 && tx_data !== q[0]) || io_buffer_full !== (q.size() >= DEPTH - MARGIN) ||
                rx_ack !== exp_ack || halt !== exp_halt || tx_overflow !== exp_ovf) begin
                errors++;
                $display("FAIL rand[%0d] got d=%h v=%b t=%h f=%b a=%b h=%b o=%b exp d=%h(k%0d) v=%b t=%h f=%b a=%b h=%b o=%b",
                         i, mem_din, tx_valid, tx_data, io_buffer_full, rx_ack, halt, tx_overflow,
                         exp_din, din_known, q.size() != 0, (q.size() != 0) ? q[0] : 8'h00,
                         q.size() >= DEPTH - MARGIN, exp_ack, exp_halt, exp_ovf);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pool[i] = 17'($urandom);
        test_reset();
        test_ram_round_trip();
        test_fifo_fill_drain();
        test_push_pop_full();
        test_rx_port();
        test_rdy_freeze();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
# mem_io_responder

Responder end of the CPU's byte-wide memory bus: it takes the address, write strobe and write byte that the core drives, and returns read bytes with one-cycle latency. Addresses below the IO window go to an on-chip byte RAM. The IO window holds a UART transmit FIFO, which also generates the core's `io_buffer_full`, plus a receive byte port and a halt register. It sits beside `cpu` in the SoC top, in place of the external RAM/HCI pairing.

## Interface
- `RAM_AW`, default 17: RAM address width; RAM holds 2^RAM_AW bytes.
- `FIFO_DEPTH`, default 8: TX FIFO entries; must be a power of two and at least 4.
- `FULL_MARGIN`, default 2: free-slot margin used to raise `io_buffer_full`.
- `clk_in`  in  1  system clock; single clock domain.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  bus enable; when low, all CPU-side side effects are frozen.
- `mem_a`  in  32  byte address from the core; only [17:0] are decoded.
- `mem_wr`  in  1  1 = write, 0 = read.
- `mem_dout`  in  8  write byte from the core.
- `mem_din`  out  8  read byte to the core (registered).
- `io_buffer_full`  out  1  TX FIFO near-full indication to the core.
- `tx_data`  out  8  FIFO head byte to the UART transmitter.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  UART accepts `tx_data` this cycle.
- `rx_data`  in  8  received UART byte.
- `rx_valid`  in  1  `rx_data` holds an unread byte.
- `rx_ack`  out  1  one-cycle pulse: `rx_data` has been consumed.
- `halt`  out  1  sticky; set when software writes the halt register.
- `tx_overflow`  out  1  sticky; set when a write hits a full FIFO.

## Operation
- **Decode.** IO when `mem_a[17:16] == 2'b11`; otherwise RAM at index `mem_a[RAM_AW-1:0]`. Upper address bits are ignored and aliasing is intended.
- **RAM write.** At a rising edge with `rdy_in`, `mem_wr=1` and a RAM address, the RAM byte is written with `mem_dout`.
- **RAM read.** At a rising edge with `rdy_in` and `mem_wr=0`, `mem_din` is loaded with the addressed byte. During a RAM write cycle, `mem_din` is loaded with `mem_dout` (write-first).
- **IO 0x30000, write.** Pushes `mem_dout` into the TX FIFO. If the FIFO is full and no pop happens in the same cycle, the byte is dropped and `tx_overflow` is set.
- **IO 0x30000, read.** `mem_din` is loaded with `rx_data` if `rx_valid`, else 8'h00. If `rx_valid`, `rx_ack` pulses for exactly one cycle after that edge.
- **IO 0x30004, write.** Sets `halt`; the data value is ignored.
- **IO 0x30004, read.** Returns {7'b0, FIFO empty}.
- **Other IO addresses.** Reads return 8'h00; writes are ignored.
- **FIFO.**
  - Circular buffer with read and write pointers that wrap modulo `FIFO_DEPTH`.
  - `count` is `$clog2(FIFO_DEPTH)+1` bits wide, range 0..FIFO_DEPTH.
  - `tx_valid = (count != 0)` and `tx_data` = head entry, both taken directly from registers.
  - Pop happens on `tx_valid && tx_ready`.
  - Push and pop in the same cycle: both occur and `count` is unchanged. This holds even when the FIFO is full, because the pop frees the slot.
- **Near-full.** `io_buffer_full = (count >= FIFO_DEPTH - FULL_MARGIN)`, decoded directly from the `count` register. The margin absorbs the writes the core already has in flight after it samples the flag.
- **`rdy_in` low.**
  - Blocked: RAM writes, FIFO pushes, `rx_ack`, and setting `halt` / `tx_overflow`.
  - Held: `mem_din` keeps its value.
  - Still running: FIFO pops, so the UART keeps draining.
- **Reset (`rst_n_in` low, any time).**
  - `mem_din`=0, FIFO empty (pointers and count 0), `tx_valid`=0, `io_buffer_full`=0, `rx_ack`=0, `halt`=0, `tx_overflow`=0.
  - RAM contents are not reset and are preserved across reset.
  - In-flight FIFO bytes are discarded.

## Timing
- Read latency is 1 cycle: an address presented in cycle k gives valid `mem_din` in cycle k+1, matching the core's sampling.
- Back-to-back reads at distinct addresses sustain one byte per cycle.
- A write at edge k is visible to a read addressed in cycle k+1.
- FIFO latency: a byte pushed at edge k drives `tx_valid` from cycle k+1.
- `io_buffer_full` changes 1 cycle after the push or pop that crosses the threshold.
- `rx_ack` is asserted in cycle k+1 for an IO read sampled at edge k. The source must drop or replace `rx_valid` by cycle k+2.
- Asynchronous reset acts immediately. Deassertion is synchronised externally; the first active edge after release may carry a transaction.

## Test plan
- **RAM round trip.** Write 0xA5 to 0x00010, then 0x3C to 0x1FFFF; read both back-to-back -> `mem_din` = 0xA5, then 0x3C, each 1 cycle after its address.
- **FIFO fill and drain.** With `tx_ready`=0, write bytes 1..8 to 0x30000 -> `io_buffer_full` rises after the 6th push, `tx_overflow` stays 0. A 9th write sets `tx_overflow`. Then with `tx_ready`=1 -> `tx_data` yields 1..8 in order, `tx_valid` falls after 8 pops, pointers wrap correctly on a refill.
- **Simultaneous push/pop at full.** FIFO full, `tx_ready`=1 plus a write of 0x77 in the same cycle -> `count` stays 8, `tx_overflow` stays 0, and 0x77 is the last byte out.
- **RX port.** `rx_valid`=1, `rx_data`=0x42, read 0x30000 -> `mem_din`=0x42 and a single `rx_ack` pulse. With `rx_valid`=0 -> `mem_din`=0x00 and no `rx_ack`.
- **`rdy_in` freeze.** `rdy_in`=0 during a RAM write of 0x11 and an IO write -> RAM and FIFO unchanged and `mem_din` held, while a pending FIFO byte still pops on `tx_ready`.
- **Reset mid-operation.** Assert `rst_n_in` low with 3 bytes queued and `halt`=1 -> all outputs go to their reset values immediately. A previously written RAM byte still reads back correctly after release.
